// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one 8x8 unsigned multiplier between two valid/ready clients.
// Optional op_count output enabled by defining MULT_SHARE_OPCOUNT_EN.

module array_multiplier_8bit (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] z
);
  always_comb begin
    z = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) z = z + (16'(a) << i);
    end
  end
endmodule

module mult_share_arbiter #(
  parameter int unsigned CALC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [15:0] rsp0_z,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [15:0] rsp1_z,
  output logic        busy,
  output logic        grant_id
`ifdef MULT_SHARE_OPCOUNT_EN
  ,
  output logic [15:0] op_count
`endif
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [1:0] CNT_LAST = 2'(CALC_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  op_a_q, op_a_d;
  logic [7:0]  op_b_q, op_b_d;
  logic [15:0] result_q, result_d;
  logic        grant_id_q, grant_id_d;
  logic        last_grant_q, last_grant_d;
  logic [15:0] mult_z;
  logic        sel_any;
  logic        sel;
  logic        rsp_done;

  // Multiplier sees only the registered operands.
  array_multiplier_8bit u_mult (
    .a (op_a_q),
    .b (op_b_q),
    .z (mult_z)
  );

  always_comb begin
    sel_any      = req0_valid | req1_valid;
    // Requester 1 wins when alone, or on a tie when requester 0 went last.
    sel          = req1_valid & (~req0_valid | ~last_grant_q);
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    result_d     = result_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    rsp0_valid   = 1'b0;
    rsp1_valid   = 1'b0;
    rsp0_z       = '0;
    rsp1_z       = '0;
    case (state_q)
      IDLE: begin
        req0_ready = ~rst & sel_any & ~sel;
        req1_ready = ~rst & sel_any & sel;
        if (sel_any) begin
          op_a_d       = sel ? req1_a : req0_a;
          op_b_d       = sel ? req1_b : req0_b;
          grant_id_d   = sel;
          last_grant_d = sel;
          cnt_d        = '0;
          state_d      = CALC;
        end
      end
      CALC: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == CNT_LAST) begin
          result_d = mult_z;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (grant_id_q) begin
          rsp1_valid = 1'b1;
          rsp1_z     = result_q;
          if (rsp1_ready) state_d = IDLE;
        end else begin
          rsp0_valid = 1'b1;
          rsp0_z     = result_q;
          if (rsp0_ready) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      result_q     <= '0;
      grant_id_q   <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      result_q     <= result_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign grant_id = grant_id_q;
  assign rsp_done = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);

`ifdef MULT_SHARE_OPCOUNT_EN
  logic [15:0] op_count_q, op_count_d;

  always_comb begin
    op_count_d = op_count_q;
    if (rsp_done) op_count_d = op_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) op_count_q <= '0;
    else     op_count_q <= op_count_d;
  end

  assign op_count = op_count_q;
`else
  logic unused_rsp_done;
  assign unused_rsp_done = rsp_done;
`endif
endmodule
